// File: rtl/alu_mdu.sv
// alu_mdu: iterative multiply/divide unit.
// Radix-2 shift-add multiply and radix-2 restoring divide on operand
// magnitudes, followed by one sign-correction cycle. Results are
// registered and change only when done pulses.
`timescale 1ns/1ps
module alu_mdu #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic             div_by_zero
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      FIX  = 2'd2
   } state_t;

   localparam logic [WIDTH-1:0] ITER     = WIDTH;
   localparam logic [WIDTH-1:0] CNT_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
   localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
   localparam logic [WIDTH-1:0] ZERO_W   = {WIDTH{1'b0}};

   state_t               state_r;
   state_t               state_s;
   logic [1:0]           op_r;
   logic [2*WIDTH-1:0]   acc_r;      // mult: {partial product, multiplier}; div: {remainder, dividend/quotient}
   logic [WIDTH-1:0]     opnd_r;     // multiplicand magnitude or divisor magnitude
   logic [WIDTH-1:0]     a_raw_r;    // untouched dividend, returned on divide by zero
   logic [WIDTH-1:0]     cnt_r;
   logic                 sa_r;
   logic                 sb_r;
   logic                 dz_r;       // divide by zero detected at acceptance
   logic                 busy_r;
   logic                 done_r;
   logic [WIDTH-1:0]     hi_r;
   logic [WIDTH-1:0]     lo_r;
   logic                 dbz_r;

   logic [WIDTH-1:0]     mag_a_s;
   logic [WIDTH-1:0]     mag_b_s;
   logic [WIDTH:0]       mul_sum_s;
   logic [WIDTH:0]       div_part_s;
   logic [WIDTH-1:0]     div_rem_s;
   logic                 div_ge_s;
   logic [2*WIDTH-1:0]   acc_step_s;
   logic [2*WIDTH-1:0]   prod_neg_s;
   logic [WIDTH-1:0]     fix_hi_s;
   logic [WIDTH-1:0]     fix_lo_s;

   assign busy        = busy_r;
   assign done        = done_r;
   assign hi          = hi_r;
   assign lo          = lo_r;
   assign div_by_zero = dbz_r;

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // Next-state logic: WIDTH iterations in CALC, or one when dividing by zero.
   always_comb begin
      state_s = state_r;
      case (state_r)
         IDLE: begin
            if (start) state_s = CALC;
            else       state_s = IDLE;
         end
         CALC: begin
            if (dz_r || (cnt_r == CNT_ONE)) state_s = FIX;
            else                            state_s = CALC;
         end
         FIX:     state_s = IDLE;
         default: state_s = IDLE;
      endcase
   end

   // Operand magnitudes, one iteration step, and final sign correction.
   always_comb begin
      mag_a_s    = (op[0] && a[WIDTH-1]) ? (~a + CNT_ONE) : a;
      mag_b_s    = (op[0] && b[WIDTH-1]) ? (~b + CNT_ONE) : b;
      mul_sum_s  = {1'b0, acc_r[2*WIDTH-1:WIDTH]} + (acc_r[0] ? {1'b0, opnd_r} : {1'b0, ZERO_W});
      div_part_s = {acc_r[2*WIDTH-1:WIDTH], acc_r[WIDTH-1]};
      div_ge_s   = (div_part_s >= {1'b0, opnd_r});
      div_rem_s  = div_part_s[WIDTH-1:0] - opnd_r;
      acc_step_s = acc_r;
      if (op_r[1]) begin
         acc_step_s = {(div_ge_s ? div_rem_s : div_part_s[WIDTH-1:0]), acc_r[WIDTH-2:0], div_ge_s};
      end else begin
         acc_step_s = {mul_sum_s, acc_r[WIDTH-1:1]};
      end
      prod_neg_s = ~acc_r + {{(2*WIDTH-1){1'b0}}, 1'b1};
      fix_hi_s   = acc_r[2*WIDTH-1:WIDTH];
      fix_lo_s   = acc_r[WIDTH-1:0];
      if (dz_r) begin
         fix_hi_s = a_raw_r;
         fix_lo_s = ALL_ONES;
      end else begin
         case (op_r)
            2'b01: begin
               if (sa_r ^ sb_r) begin
                  fix_hi_s = prod_neg_s[2*WIDTH-1:WIDTH];
                  fix_lo_s = prod_neg_s[WIDTH-1:0];
               end else begin
                  fix_hi_s = acc_r[2*WIDTH-1:WIDTH];
                  fix_lo_s = acc_r[WIDTH-1:0];
               end
            end
            2'b11: begin
               fix_lo_s = (sa_r ^ sb_r) ? (~acc_r[WIDTH-1:0] + CNT_ONE) : acc_r[WIDTH-1:0];
               fix_hi_s = sa_r ? (~acc_r[2*WIDTH-1:WIDTH] + CNT_ONE) : acc_r[2*WIDTH-1:WIDTH];
            end
            default: begin
               fix_hi_s = acc_r[2*WIDTH-1:WIDTH];
               fix_lo_s = acc_r[WIDTH-1:0];
            end
         endcase
      end
   end

   // Datapath: load on acceptance, iterate in CALC, publish results in FIX.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_r    <= 2'b00;
         acc_r   <= {(2*WIDTH){1'b0}};
         opnd_r  <= ZERO_W;
         a_raw_r <= ZERO_W;
         cnt_r   <= ZERO_W;
         sa_r    <= 1'b0;
         sb_r    <= 1'b0;
         dz_r    <= 1'b0;
         hi_r    <= ZERO_W;
         lo_r    <= ZERO_W;
         dbz_r   <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               if (start) begin
                  op_r    <= op;
                  a_raw_r <= a;
                  cnt_r   <= ITER;
                  sa_r    <= op[0] & a[WIDTH-1];
                  sb_r    <= op[0] & b[WIDTH-1];
                  dz_r    <= op[1] & (b == ZERO_W);
                  if (op[1]) begin
                     acc_r  <= {ZERO_W, mag_a_s};
                     opnd_r <= mag_b_s;
                  end else begin
                     acc_r  <= {ZERO_W, mag_b_s};
                     opnd_r <= mag_a_s;
                  end
               end else begin
                  cnt_r <= cnt_r;
               end
            end
            CALC: begin
               acc_r <= acc_step_s;
               cnt_r <= cnt_r - CNT_ONE;
            end
            FIX: begin
               hi_r  <= fix_hi_s;
               lo_r  <= fix_lo_s;
               dbz_r <= dz_r;
            end
            default: begin
               cnt_r <= ZERO_W;
            end
         endcase
      end
   end

   // Registered handshake outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy_r <= 1'b0;
         done_r <= 1'b0;
      end else begin
         busy_r <= (state_s != IDLE);
         done_r <= (state_r == FIX);
      end
   end

endmodule

// File: tb/tb_alu_mdu.sv
// Self-checking bench for alu_mdu (WIDTH=32): directed corner cases plus
// random operations compared against a plain-arithmetic reference model.
`timescale 1ns/1ps
module tb_alu_mdu;
   localparam int W = 32;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         start = 1'b0;
   logic [1:0]   op = 2'b00;
   logic [W-1:0] a = '0;
   logic [W-1:0] b = '0;
   logic         busy;
   logic         done;
   logic [W-1:0] hi;
   logic [W-1:0] lo;
   logic         div_by_zero;

   int checks = 0;
   int errors = 0;
   int since_k = 0;
   logic [W-1:0] exp_hi, exp_lo, prev_hi, prev_lo;
   logic         exp_dz;
   int           exp_lat;

   alu_mdu #(.WIDTH(W)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
      .busy(busy), .done(done), .hi(hi), .lo(lo), .div_by_zero(div_by_zero)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      since_k++;
   endtask

   // Reference: plain 64-bit arithmetic on the architectural meaning of each op.
   task automatic model(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
      longint sx, sy, q, r;
      logic [63:0] p;
      sx = $signed(x);
      sy = $signed(y);
      exp_dz  = 1'b0;
      exp_lat = W + 1;
      case (o)
         2'b00: begin
            p = {32'h0, x} * {32'h0, y};
            exp_hi = p[63:32]; exp_lo = p[31:0];
         end
         2'b01: begin
            q = sx * sy; p = q;
            exp_hi = p[63:32]; exp_lo = p[31:0];
         end
         default: begin
            if (y == 32'h0) begin
               exp_hi = x; exp_lo = 32'hFFFF_FFFF; exp_dz = 1'b1; exp_lat = 2;
            end else if (o == 2'b10) begin
               exp_lo = x / y; exp_hi = x % y;
            end else begin
               q = sx / sy; r = sx % sy;
               exp_lo = q[31:0]; exp_hi = r[31:0];
            end
         end
      endcase
   endtask

   // Present a request now (between edges); returns #1 after the acceptance edge.
   task automatic launch(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
      op = o; a = x; b = y; start = 1'b1;
      model(o, x, y);
      prev_hi = hi; prev_lo = lo;
      @(posedge clk);
      #1;
      start = 1'b0;
      since_k = 0;
      chk("busy_accept", {63'h0, busy}, 64'h1);
   endtask

   // Wait for done with a bounded budget, then check timing and results.
   task automatic finish(input bit hold_chk);
      while (done !== 1'b1 && since_k < 200) begin
         chk("busy_inflight", {63'h0, busy}, 64'h1);
         chk("hi_stable", {32'h0, hi}, {32'h0, prev_hi});
         chk("lo_stable", {32'h0, lo}, {32'h0, prev_lo});
         tick();
      end
      chk("latency", since_k, exp_lat);
      chk("done", {63'h0, done}, 64'h1);
      chk("busy_low", {63'h0, busy}, 64'h0);
      chk("hi", {32'h0, hi}, {32'h0, exp_hi});
      chk("lo", {32'h0, lo}, {32'h0, exp_lo});
      chk("div_by_zero", {63'h0, div_by_zero}, {63'h0, exp_dz});
      if (hold_chk) begin
         tick();
         chk("done_pulse", {63'h0, done}, 64'h0);
         chk("hi_hold", {32'h0, hi}, {32'h0, exp_hi});
         chk("lo_hold", {32'h0, lo}, {32'h0, exp_lo});
      end
   endtask

   task automatic run(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
      @(negedge clk);
      launch(o, x, y);
      finish(1'b1);
   endtask

   initial begin
      logic [1:0]   ro;
      logic [W-1:0] rx, ry;
      int           sel;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      chk("rst_busy", {63'h0, busy}, 64'h0);
      chk("rst_done", {63'h0, done}, 64'h0);
      chk("rst_hi", {32'h0, hi}, 64'h0);
      chk("rst_lo", {32'h0, lo}, 64'h0);
      chk("rst_dbz", {63'h0, div_by_zero}, 64'h0);
      @(negedge clk);
      rst_n = 1'b1;

      // Directed corner cases
      run(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      run(2'b01, 32'hFFFF_FFFD, 32'h0000_0005);
      run(2'b11, 32'hFFFF_FFF9, 32'h0000_0002);
      run(2'b10, 32'h0000_0064, 32'h0000_0000);
      run(2'b10, 32'h0000_0064, 32'h0000_0007);
      run(2'b11, 32'h8000_0000, 32'hFFFF_FFFF);
      run(2'b01, 32'h8000_0000, 32'h8000_0000);
      run(2'b11, 32'h0000_0007, 32'hFFFF_FFFE);
      run(2'b11, 32'hFFFF_FFF0, 32'h0000_0000);

      // start while busy is ignored
      @(negedge clk);
      launch(2'b00, 32'h1234_5678, 32'h9ABC_DEF0);
      repeat (9) tick();
      op = 2'b11; a = 32'hDEAD_BEEF; b = 32'h0000_0003; start = 1'b1;
      tick();
      start = 1'b0;
      finish(1'b1);

      // start in the done cycle is accepted (back-to-back)
      @(negedge clk);
      launch(2'b01, 32'h0000_1234, 32'hFFFF_FF00);
      finish(1'b0);
      launch(2'b10, 32'hCAFE_F00D, 32'h0000_0101);
      finish(1'b1);

      // Random operations
      for (int i = 0; i < 40; i++) begin
         ro  = 2'($urandom_range(0, 3));
         rx  = $urandom;
         sel = $urandom_range(0, 9);
         if (sel == 0)      ry = 32'h0;
         else if (sel == 1) ry = 32'hFFFF_FFFF;
         else if (sel == 2) ry = 32'($urandom_range(1, 20));
         else               ry = $urandom;
         if ($urandom_range(0, 7) == 0) rx = 32'h8000_0000;
         run(ro, rx, ry);
      end

      // Reset mid-operation aborts without done
      @(negedge clk);
      launch(2'b11, 32'h7FFF_0001, 32'h0000_0013);
      repeat (14) tick();
      rst_n = 1'b0;
      #1;
      chk("abort_busy", {63'h0, busy}, 64'h0);
      chk("abort_done", {63'h0, done}, 64'h0);
      chk("abort_hi", {32'h0, hi}, 64'h0);
      chk("abort_lo", {32'h0, lo}, 64'h0);
      chk("abort_dbz", {63'h0, div_by_zero}, 64'h0);
      repeat (3) begin
         @(posedge clk);
         #1;
         chk("abort_no_done", {63'h0, done}, 64'h0);
      end
      @(negedge clk);
      rst_n = 1'b1;
      run(2'b11, 32'h7FFF_0001, 32'h0000_0013);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/alu_mdu.md
ALU_MDU -- requirements
Module: alu_mdu

Interface
REQ-001: Parameter WIDTH, default 32, operand and result-half width in bits; legal values 8..64.
REQ-002: clk  input  1  rising-edge clock for all state.
REQ-003: rst_n  input  1  asynchronous, active-low reset.
REQ-004: start  input  1  request pulse; sampled only in IDLE.
REQ-005: op  input  2  operation: 00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
REQ-006: a  input  WIDTH  multiplicand / dividend; sampled with start.
REQ-007: b  input  WIDTH  multiplier / divisor; sampled with start.
REQ-008: busy  output  1  high while an operation is in flight.
REQ-009: done  output  1  one-cycle pulse; hi/lo hold the new result.
REQ-010: hi  output  WIDTH  product upper half, or remainder.
REQ-011: lo  output  WIDTH  product lower half, or quotient.
REQ-012: div_by_zero  output  1  flag for the last completed operation: high if it was a divide with b==0.

Function
REQ-013: FSM states SHALL be IDLE, CALC, FIX.
- IDLE->CALC on start.
- CALC->FIX after exactly WIDTH iterations.
- FIX->IDLE unconditionally.
REQ-014: On acceptance (start=1 in IDLE at edge k):
- SHALL latch op, a, b.
- SHALL load a WIDTH-bit iteration counter.
- SHALL take magnitudes of a and b for MULT/DIV; MULTU/DIVU use raw values.
REQ-015: Multiply (CALC) SHALL be radix-2 shift-add: one multiplier bit per cycle into a 2*WIDTH-bit accumulator.
REQ-016: Divide (CALC) SHALL be radix-2 restoring division: one quotient bit per cycle, WIDTH-bit remainder plus a carry bit.
REQ-017: FIX SHALL apply sign correction for signed ops.
- MULT: negate the 2*WIDTH product if sign(a)^sign(b).
- DIV: negate the quotient if sign(a)^sign(b); remainder takes the sign of a.
REQ-018: Timing from acceptance edge k:
- busy high after edges k..k+WIDTH.
- hi, lo, div_by_zero and a one-cycle done update at edge k+WIDTH+1.
- busy low from edge k+WIDTH+1.
REQ-019: start SHALL be ignored while busy=1; the in-flight operation is unaffected.
REQ-020: start asserted in the same cycle as done (FSM in IDLE) SHALL be accepted, giving back-to-back operation.
REQ-021: Divide by zero (b==0, DIVU or DIV):
- FSM SHALL go CALC->FIX after one cycle; done at edge k+2.
- hi SHALL equal a (unmodified); lo SHALL equal all-ones.
- div_by_zero SHALL be 1.
REQ-022: DIV with a = most-negative and b = -1 SHALL give lo = most-negative (wrap) and hi = 0, with no flag.
REQ-023: hi, lo and div_by_zero SHALL hold their value between done pulses.
- Intermediate accumulator values SHALL never appear on hi/lo.
REQ-024: All arithmetic SHALL be modulo 2^(2*WIDTH) for products and modulo 2^WIDTH per half, with no overflow flag.

Reset
REQ-025: rst_n=0 SHALL asynchronously force:
- state IDLE, busy=0, done=0, div_by_zero=0;
- hi=0, lo=0, counter=0.
REQ-026: Reset asserted mid-operation SHALL abort the operation with no done pulse.
- The first start after rst_n rises SHALL be accepted normally.

Verification (WIDTH=32)
REQ-027: MULTU a=FFFFFFFF b=FFFFFFFF -> done at edge k+33, hi=FFFFFFFE, lo=00000001, busy high 33 cycles.
REQ-028: MULT a=FFFFFFFD(-3) b=00000005 -> hi=FFFFFFFF, lo=FFFFFFF1; DIV a=FFFFFFF9(-7) b=2 -> lo=FFFFFFFD, hi=FFFFFFFF.
REQ-029: DIVU a=00000064 b=0 -> done at edge k+2, hi=00000064, lo=FFFFFFFF, div_by_zero=1; a following DIVU 100/7 -> lo=0000000E, hi=00000002, div_by_zero=0.
REQ-030: DIV a=80000000 b=FFFFFFFF -> lo=80000000, hi=00000000; MULT 80000000*80000000 -> hi=40000000, lo=00000000.
REQ-031: start pulsed with new operands at edge k+10 during a MULTU -> ignored, result unchanged; start in the done cycle -> accepted, second done exactly 33 cycles later.
REQ-032: rst_n low at edge k+15 of a DIV -> immediate busy=0, hi=lo=0, no done; next start completes correctly.
